// File: rtl/aura_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : aura_pkg                                                 |
// | Description : Shared types and default dimensions for the attention    |
// |               datapath: element/vector types and the feeder FSM state. |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package aura_pkg;

  // Default dimensions of the attention block.
  localparam int AURA_SEQ_LEN   = 16;
  localparam int AURA_DK        = 64;
  localparam int AURA_INT_WIDTH = 8;

  // Signed element and packed row vectors; element i sits at [i*INT_WIDTH +: INT_WIDTH].
  typedef logic signed [AURA_INT_WIDTH-1:0] INT_T;
  typedef INT_T [AURA_DK-1:0]               Q_VECTOR_T;
  typedef INT_T [AURA_DK-1:0]               K_VECTOR_T;
  typedef INT_T [AURA_DK-1:0]               V_VECTOR_T;

  // Feeder sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } feeder_state_t;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_fetch.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : stream_fetch                                             |
// | Description : One feeder stream: row address and pass counters, a      |
// |               single outstanding SRAM read, and a 2-entry prefetch     |
// |               FIFO presenting a valid/ready source downstream.         |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module stream_fetch
  import aura_pkg::*;
#(
  parameter int ROWS   = 16,
  parameter int PASSES = 1,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              enable_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] addr_o,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              vld_o,
  input  logic              rdy_i,
  output logic [DATA_W-1:0] data_o,
  output logic              issued_all_o,
  output logic              drained_o
);

  localparam int PASS_W = cnt_width(PASSES);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic              issued_all_q, issued_all_d;
  logic              outstanding_q;
  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q;

  logic              w_pop;
  logic              w_issue;
  logic [2:0]        w_level;

  assign w_pop        = vld_o && rdy_i;
  assign vld_o        = (count_q != 2'd0);
  assign data_o       = mem_q[rd_ptr_q];
  assign rd_en_o      = w_issue;
  assign addr_o       = addr_q;
  assign issued_all_o = issued_all_q;
  // Nothing left in flight and the buffer is empty once this cycle's pop (if any) lands.
  assign drained_o    = issued_all_q && !outstanding_q && (count_q == {1'b0, w_pop});

  // Fetch decision and counter advance. The level counts the head leaving
  // this cycle so a read can be issued every cycle under continuous ready.
  always_comb begin
    w_level      = {1'b0, count_q} + {2'b00, outstanding_q} - {2'b00, w_pop};
    w_issue      = enable_i && !issued_all_q && (w_level < 3'd2);
    addr_d       = addr_q;
    pass_d       = pass_q;
    issued_all_d = issued_all_q;
    if (w_issue) begin
      if (addr_q == ADDR_W'(ROWS - 1)) begin
        addr_d = '0;
        pass_d = pass_q + 1'b1;
        if (pass_q == PASS_W'(PASSES - 1)) begin
          issued_all_d = 1'b1;
        end
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  // Counters, read-in-flight flag and FIFO storage; read data lands the cycle after the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q        <= '0;
      pass_q        <= '0;
      issued_all_q  <= 1'b0;
      outstanding_q <= 1'b0;
      mem_q[0]      <= '0;
      mem_q[1]      <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
    end else begin
      if (clear_i) begin
        addr_q       <= '0;
        pass_q       <= '0;
        issued_all_q <= 1'b0;
      end else begin
        addr_q       <= addr_d;
        pass_q       <= pass_d;
        issued_all_q <= issued_all_d;
      end
      outstanding_q <= w_issue;
      if (outstanding_q) begin
        mem_q[wr_ptr_q] <= rdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (w_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, outstanding_q} - {1'b0, w_pop};
    end
  end

endmodule
`default_nettype wire

// File: rtl/qkv_stream_feeder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : qkv_stream_feeder                                        |
// | Description : Streams Q (once per row) and K/V (SEQ_LEN passes each)   |
// |               from three synchronous-read SRAMs to the attention       |
// |               dot-product stage over valid/ready.                      |
// |               Optional stall counter: define QKV_FEEDER_PERF_EN.       |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module qkv_stream_feeder
  import aura_pkg::*;
#(
  parameter int SEQ_LEN   = AURA_SEQ_LEN,
  parameter int DK        = AURA_DK,
  parameter int INT_WIDTH = AURA_INT_WIDTH,
  parameter int ADDR_W    = $clog2(SEQ_LEN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    q_mem_rd_en,
  output logic                    k_mem_rd_en,
  output logic                    v_mem_rd_en,
  output logic [ADDR_W-1:0]       q_mem_addr,
  output logic [ADDR_W-1:0]       k_mem_addr,
  output logic [ADDR_W-1:0]       v_mem_addr,
  input  logic [DK*INT_WIDTH-1:0] q_mem_rdata,
  input  logic [DK*INT_WIDTH-1:0] k_mem_rdata,
  input  logic [DK*INT_WIDTH-1:0] v_mem_rdata,
  output logic                    q_vld_out,
  output logic                    k_vld_out,
  output logic                    v_vld_out,
  input  logic                    q_rdy_in,
  input  logic                    k_rdy_in,
  input  logic                    v_rdy_in,
  output logic [DK*INT_WIDTH-1:0] q_out,
  output logic [DK*INT_WIDTH-1:0] k_out,
  output logic [DK*INT_WIDTH-1:0] v_out
`ifdef QKV_FEEDER_PERF_EN
  ,
  output logic [31:0]             stall_count
`endif
);

  localparam int DATA_W = DK * INT_WIDTH;

  feeder_state_t state_q, state_d;
  logic          w_start_acc;
  logic          w_run;
  logic [2:0]    w_issued_all;
  logic [2:0]    w_drained;

  assign w_start_acc = (state_q == ST_IDLE) && start;
  assign w_run       = (state_q == ST_RUN);

  stream_fetch #(.ROWS(SEQ_LEN), .PASSES(1), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_q_fetch (
    .clk(clk), .rst(rst), .clear_i(w_start_acc), .enable_i(w_run),
    .rd_en_o(q_mem_rd_en), .addr_o(q_mem_addr), .rdata_i(q_mem_rdata),
    .vld_o(q_vld_out), .rdy_i(q_rdy_in), .data_o(q_out),
    .issued_all_o(w_issued_all[0]), .drained_o(w_drained[0])
  );

  stream_fetch #(.ROWS(SEQ_LEN), .PASSES(SEQ_LEN), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_k_fetch (
    .clk(clk), .rst(rst), .clear_i(w_start_acc), .enable_i(w_run),
    .rd_en_o(k_mem_rd_en), .addr_o(k_mem_addr), .rdata_i(k_mem_rdata),
    .vld_o(k_vld_out), .rdy_i(k_rdy_in), .data_o(k_out),
    .issued_all_o(w_issued_all[1]), .drained_o(w_drained[1])
  );

  stream_fetch #(.ROWS(SEQ_LEN), .PASSES(SEQ_LEN), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_v_fetch (
    .clk(clk), .rst(rst), .clear_i(w_start_acc), .enable_i(w_run),
    .rd_en_o(v_mem_rd_en), .addr_o(v_mem_addr), .rdata_i(v_mem_rdata),
    .vld_o(v_vld_out), .rdy_i(v_rdy_in), .data_o(v_out),
    .issued_all_o(w_issued_all[2]), .drained_o(w_drained[2])
  );

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and status outputs; DONE lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (&w_issued_all) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (&w_drained) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef QKV_FEEDER_PERF_EN
  logic [31:0] stall_q;
  logic        w_any_stall;

  assign w_any_stall = (q_vld_out && !q_rdy_in) || (k_vld_out && !k_rdy_in) ||
                       (v_vld_out && !v_rdy_in);
  assign stall_count = stall_q;

  // Saturating count of cycles where any stream is held off by its consumer.
  always_ff @(posedge clk) begin
    if (rst || w_start_acc) begin
      stall_q <= '0;
    end else if (w_any_stall && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire
